// File: rtl/simon_pkg.sv
// Shared Simon game types, result-word bit positions and speed codes.
// Used by the controller and the player-input evaluation block.
package simon_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_DONE
  } eval_state_t;

  localparam int VAL_DONE    = 5;
  localparam int VAL_PASS    = 4;
  localparam int VAL_TIMEOUT = 3;
  localparam int VAL_WRONG   = 2;

  localparam logic [1:0] SPEED_SLOW = 2'b00;
  localparam logic [1:0] SPEED_MED  = 2'b01;
  localparam logic [1:0] SPEED_FAST = 2'b10;

  function automatic logic is_onehot4(
    input logic [3:0] v
  );
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic color_t enc4(
    input logic [3:0] v
  );
    color_t c;
    if (v[3])      c = BLUE;
    else if (v[2]) c = RED;
    else if (v[1]) c = YELLOW;
    else           c = GREEN;
    return c;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-count filter for a button vector.
// The output moves only after the input holds one value long enough.
module button_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset_button,
  input  logic [WIDTH-1:0] raw_button,
  output logic [WIDTH-1:0] debounced
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;

  // A fresh value restarts the run length at one observation.
  always_comb begin
    cnt_n = (sync2 != cand) ? CW'(1) : cnt + CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset_button) begin
    if (i_reset_button) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      cnt       <= '0;
      debounced <= '0;
    end else begin
      sync1 <= raw_button;
      sync2 <= sync1;
      cand  <= sync2;
      if (sync2 == debounced) begin
        cnt <= '0;
      end else if (cnt_n == CW'(DEBOUNCE_CYCLES)) begin
        debounced <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt_n;
      end
    end
  end

endmodule

// File: rtl/evaluation_module.sv
// Simon player-input responder: debounces buttons, echoes presses,
// checks them against the sequence and reports a done/result word.
module evaluation_module
  import simon_pkg::*;
#(
  parameter int MAX_LEN         = 32,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int TIMEOUT_BASE    = 200_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_button,
  input  logic                 i_enable,
  input  logic [2*MAX_LEN-1:0] i_seq,
  input  logic [5:0]           i_seq_len,
  input  logic [1:0]           i_speed,
  input  logic [3:0]           i_play_button,
  output logic [3:0]           o_led_color,
  output logic [5:0]           o_value,
  output logic [5:0]           o_step_count
);

  localparam logic [31:0] T1 = 32'(TIMEOUT_BASE);
  localparam logic [31:0] T2 = 32'(2 * TIMEOUT_BASE);
  localparam logic [31:0] T4 = 32'(4 * TIMEOUT_BASE);

  eval_state_t state;
  eval_state_t state_n;
  logic [3:0]  db;
  logic [3:0]  db_prev;
  logic [5:0]  idx;
  logic [5:0]  idx_n;
  logic [5:0]  len;
  logic [5:0]  len_n;
  logic [5:0]  len_clamp;
  logic [31:0] timer;
  logic [31:0] timer_n;
  logic [31:0] timeout_load;
  logic [3:0]  led_n;
  logic [5:0]  value_n;
  logic [5:0]  count_n;
  logic        press_evt;
  color_t      press_c;
  logic [1:0]  exp_c;

  button_debouncer #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .i_clk          (i_clk),
    .i_reset_button (i_reset_button),
    .raw_button     (i_play_button),
    .debounced      (db)
  );

  // Only a clean 0000 -> single-button step counts as a press.
  assign press_evt = (db_prev == 4'd0) && is_onehot4(db);
  assign press_c   = enc4(db);
  assign len_clamp = (i_seq_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : i_seq_len;

  always_comb begin
    exp_c = 2'd0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (idx == 6'(k)) exp_c = i_seq[2*k +: 2];
    end
  end

  always_comb begin
    case (i_speed)
      SPEED_SLOW: timeout_load = T4;
      SPEED_MED:  timeout_load = T2;
      default:    timeout_load = T1;
    endcase
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len;
    timer_n = timer;
    led_n   = o_led_color;
    value_n = o_value;
    count_n = o_step_count;
    if (!i_enable) begin
      state_n = S_IDLE;
      idx_n   = '0;
      led_n   = '0;
      value_n = '0;
      count_n = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          idx_n   = '0;
          led_n   = '0;
          value_n = '0;
          count_n = '0;
          len_n   = len_clamp;
          if (len_clamp == 6'd0) begin
            state_n            = S_DONE;
            value_n[VAL_DONE]  = 1'b1;
            value_n[VAL_PASS]  = 1'b1;
          end else begin
            state_n = S_WAIT_PRESS;
            timer_n = timeout_load;
          end
        end
        S_WAIT_PRESS: begin
          if (timer != 32'd0) timer_n = timer - 32'd1;
          // A press in the expiry cycle still wins.
          if (press_evt) begin
            value_n[1:0] = press_c;
            if (press_c != exp_c) begin
              state_n            = S_DONE;
              value_n[VAL_DONE]  = 1'b1;
              value_n[VAL_WRONG] = 1'b1;
            end else begin
              led_n   = 4'b0001 << press_c;
              state_n = S_WAIT_RELEASE;
            end
          end else if (timer <= 32'd1) begin
            state_n              = S_DONE;
            value_n[VAL_DONE]    = 1'b1;
            value_n[VAL_TIMEOUT] = 1'b1;
          end
        end
        S_WAIT_RELEASE: begin
          if (db == 4'd0) begin
            led_n   = '0;
            idx_n   = idx + 6'd1;
            count_n = o_step_count + 6'd1;
            if (idx + 6'd1 == len) begin
              state_n           = S_DONE;
              value_n[VAL_DONE] = 1'b1;
              value_n[VAL_PASS] = 1'b1;
            end else begin
              state_n = S_WAIT_PRESS;
              timer_n = timeout_load;
            end
          end
        end
        S_DONE: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset_button) begin
    if (i_reset_button) begin
      state        <= S_IDLE;
      db_prev      <= '0;
      idx          <= '0;
      len          <= '0;
      timer        <= '0;
      o_led_color  <= '0;
      o_value      <= '0;
      o_step_count <= '0;
    end else begin
      state        <= state_n;
      db_prev      <= db;
      idx          <= idx_n;
      len          <= len_n;
      timer        <= timer_n;
      o_led_color  <= led_n;
      o_value      <= value_n;
      o_step_count <= count_n;
    end
  end

endmodule

// File: tb/tb_evaluation_module.sv
// Directed bench for evaluation_module with short debounce/timeout.
// Expected values are hand-computed constants.
module tb_evaluation_module;

  logic        clk;
  logic        rst;
  logic        en;
  logic [63:0] seq;
  logic [5:0]  seq_len;
  logic [1:0]  speed;
  logic [3:0]  btn;
  logic [3:0]  led;
  logic [5:0]  value;
  logic [5:0]  steps;

  int checks;
  int failures;

  evaluation_module #(
    .MAX_LEN         (32),
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_BASE    (100)
  ) dut (
    .i_clk          (clk),
    .i_reset_button (rst),
    .i_enable       (en),
    .i_seq          (seq),
    .i_seq_len      (seq_len),
    .i_speed        (speed),
    .i_play_button  (btn),
    .o_led_color    (led),
    .o_value        (value),
    .o_step_count   (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw change -> debounced after 6 edges, FSM reacts on the 7th.
  task automatic drive(input logic [3:0] b);
    btn = b;
    tick(7);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    seq      = '0;
    seq_len  = '0;
    speed    = 2'b10;
    btn      = '0;
    #1;
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_steps", 32'(steps), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Full pass: red, green, blue
    seq     = 64'h32;
    seq_len = 6'd3;
    en      = 1'b1;
    tick(1);
    chk("pass_start_value", 32'(value), 32'h0);
    btn = 4'b0100;
    tick(6);
    chk("pass_red_latency", 32'(led), 32'h0);
    tick(1);
    chk("pass_red_led", 32'(led), 32'b0100);
    drive(4'b0000);
    chk("pass_rel1_led", 32'(led), 32'h0);
    chk("pass_rel1_steps", 32'(steps), 32'd1);
    drive(4'b0001);
    chk("pass_green_led", 32'(led), 32'b0001);
    drive(4'b0000);
    chk("pass_rel2_steps", 32'(steps), 32'd2);
    drive(4'b1000);
    chk("pass_blue_led", 32'(led), 32'b1000);
    chk("pass_blue_value", 32'(value), 32'b000011);
    drive(4'b0000);
    chk("pass_steps", 32'(steps), 32'd3);
    chk("pass_value", 32'(value), 32'b110011);
    drive(4'b0100);
    chk("pass_hold_value", 32'(value), 32'b110011);
    chk("pass_hold_led", 32'(led), 32'h0);
    drive(4'b0000);
    en = 1'b0;
    tick(1);
    chk("pass_clear_value", 32'(value), 32'h0);
    chk("pass_clear_steps", 32'(steps), 32'h0);

    // Wrong colour: expect yellow, press red
    seq     = 64'h1;
    seq_len = 6'd3;
    en      = 1'b1;
    tick(1);
    drive(4'b0100);
    chk("wrong_value", 32'(value), 32'b100110);
    chk("wrong_led", 32'(led), 32'h0);
    chk("wrong_steps", 32'(steps), 32'h0);
    drive(4'b0000);
    en = 1'b0;
    tick(1);

    // Timeout at medium speed: 200 cycles
    speed = 2'b01;
    en    = 1'b1;
    tick(1);
    tick(199);
    chk("timeout_early", 32'(value), 32'h0);
    tick(1);
    chk("timeout_value", 32'(value), 32'b101000);
    en = 1'b0;
    tick(1);
    speed = 2'b10;

    // Glitch and multi-press, then clean green
    seq     = 64'h0;
    seq_len = 6'd1;
    en      = 1'b1;
    tick(1);
    btn = 4'b0001;
    tick(2);
    btn = 4'b0000;
    tick(8);
    chk("glitch_led", 32'(led), 32'h0);
    chk("glitch_value", 32'(value), 32'h0);
    btn = 4'b0101;
    tick(8);
    chk("multi_led", 32'(led), 32'h0);
    btn = 4'b0000;
    tick(8);
    chk("multi_rel_value", 32'(value), 32'h0);
    drive(4'b0001);
    chk("clean_green_led", 32'(led), 32'b0001);
    drive(4'b0000);
    chk("clean_value", 32'(value), 32'b110000);
    chk("clean_steps", 32'(steps), 32'd1);
    en = 1'b0;
    tick(1);

    // Abort in WAIT_RELEASE after step 1, then restart
    seq     = 64'h2;
    seq_len = 6'd2;
    en      = 1'b1;
    tick(1);
    drive(4'b0100);
    drive(4'b0000);
    drive(4'b0001);
    chk("abort_pre_led", 32'(led), 32'b0001);
    chk("abort_pre_steps", 32'(steps), 32'd1);
    en = 1'b0;
    tick(1);
    chk("abort_led", 32'(led), 32'h0);
    chk("abort_value", 32'(value), 32'h0);
    chk("abort_steps", 32'(steps), 32'h0);
    drive(4'b0000);
    en = 1'b1;
    tick(1);
    drive(4'b0100);
    chk("restart_led", 32'(led), 32'b0100);
    chk("restart_steps", 32'(steps), 32'h0);
    drive(4'b0000);
    chk("restart_rel_steps", 32'(steps), 32'd1);
    en = 1'b0;
    tick(1);

    // Zero length passes at once
    seq_len = 6'd0;
    en      = 1'b1;
    tick(1);
    chk("len0_value", 32'(value), 32'b110000);
    en = 1'b0;
    tick(1);

    // Length 40 clamps to 32; step i colour = i mod 4
    seq     = 64'hE4E4E4E4E4E4E4E4;
    seq_len = 6'd40;
    en      = 1'b1;
    tick(1);
    for (int i = 0; i < 31; i++) begin
      drive(4'b0001 << (i % 4));
      drive(4'b0000);
    end
    chk("clamp31_steps", 32'(steps), 32'd31);
    chk("clamp31_done", 32'(value[5]), 32'h0);
    drive(4'b1000);
    drive(4'b0000);
    chk("clamp_steps", 32'(steps), 32'd32);
    chk("clamp_value", 32'(value), 32'b110011);
    en = 1'b0;
    tick(1);

    // Asynchronous reset mid-round
    seq     = 64'h2;
    seq_len = 6'd2;
    en      = 1'b1;
    tick(1);
    drive(4'b0100);
    chk("rst_pre_led", 32'(led), 32'b0100);
    rst = 1'b1;
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_steps", 32'(steps), 32'h0);
    en  = 1'b0;
    btn = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
